// File: rtl/fx_pkg.sv
// fx_pkg: word format, sequencer state type and matrix packing helper for fx_mat2_mult_seq.
package fx_pkg;

   localparam int FX_N = 32;
   localparam int FX_Q = 18;

   localparam logic [FX_N-1:0] FX_MAX = {1'b0, {(FX_N-1){1'b1}}};
   localparam logic [FX_N-1:0] FX_MIN = {1'b1, {(FX_N-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit offset of element [r][c] inside a packed 2x2 matrix of w-bit words.
   function automatic int idx(input int r, input int c, input int w = FX_N);
      return w * (2 * r + c);
   endfunction

endpackage

// File: rtl/fx_add_sat.sv
// fx_add_sat: signed N-bit add with (N+1)-bit overflow detection.
// Build option FX_MAT2_SAT_EN clamps overflowed sums to FX_MAX/FX_MIN; otherwise they wrap.
module fx_add_sat
   import fx_pkg::*;
#(
   parameter int N = FX_N
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] sum_o,
   output logic         ovr_o
);

   logic [N:0] wide;

   assign wide  = {a_i[N-1], a_i} + {b_i[N-1], b_i};
   assign ovr_o = wide[N] ^ wide[N-1];

`ifdef FX_MAT2_SAT_EN
   always_comb begin
      if (!ovr_o)      sum_o = wide[N-1:0];
      else if (wide[N]) sum_o = FX_MIN;
      else              sum_o = FX_MAX;
   end
`else
   assign sum_o = wide[N-1:0];
`endif

endmodule

// File: rtl/qmult.sv
// qmult: signed Qm.n multiply; magnitudes multiplied and truncated, sign reapplied, ovr when
// the magnitude does not fit in N-1 bits. The most negative operand wraps to magnitude 0.
module qmult #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic [N-1:0] i_multiplicand,
   input  logic [N-1:0] i_multiplier,
   output logic [N-1:0] o_result,
   output logic         ovr
);

   logic [N-2:0]   mag_a;
   logic [N-2:0]   mag_b;
   logic [N-2:0]   mag_r;
   logic [2*N-3:0] mag_p;
   logic           neg;
   logic           unused_frac;

   assign mag_a = i_multiplicand[N-1] ? (~i_multiplicand[N-2:0] + (N-1)'(1))
                                      : i_multiplicand[N-2:0];
   assign mag_b = i_multiplier[N-1]   ? (~i_multiplier[N-2:0] + (N-1)'(1))
                                      : i_multiplier[N-2:0];

   assign mag_p       = (2*N-2)'(mag_a) * (2*N-2)'(mag_b);
   assign mag_r       = mag_p[Q +: N-1];
   assign ovr         = |mag_p[2*N-3:Q+N-1];
   assign unused_frac = ^mag_p[Q-1:0];

   assign neg      = i_multiplicand[N-1] ^ i_multiplier[N-1];
   assign o_result = neg ? (~{1'b0, mag_r} + N'(1)) : {1'b0, mag_r};

endmodule

// File: rtl/fx_mat2_mult_seq.sv
// fx_mat2_mult_seq: C = A x B for 2x2 signed fixed-point matrices, 8 products on one qmult.
// Build option FX_MAT2_SAT_EN makes element sums saturate instead of wrap.
module fx_mat2_mult_seq
   import fx_pkg::*;
#(
   parameter int Q = FX_Q,
   parameter int N = FX_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [4*N-1:0] a_i,
   input  logic [4*N-1:0] b_i,
   output logic [4*N-1:0] c_o,
   output logic           busy,
   output logic           done,
   output logic           ovr
);

   state_e         state_q, state_d;
   logic [2:0]     k_q, k_d;
   logic [4*N-1:0] a_q, a_d, b_q, b_d;
   logic [4*N-1:0] res_q, res_d, c_q, c_d;
   logic [N-1:0]   acc_q, acc_d;
   logic           ovr_acc_q, ovr_acc_d;
   logic           ovr_q, ovr_d, busy_q, busy_d, done_q, done_d;

   logic [1:0]     e;
   logic           row, col, term;
   logic [N-1:0]   a_el [4];
   logic [N-1:0]   b_el [4];
   logic [N-1:0]   op_a, op_b, prod, sum;
   logic           prod_ovr, sum_ovr;

   // k walks elements in order; within each element, term 0 loads acc and term 1 adds.
   assign e    = k_q[2:1];
   assign row  = e[1];
   assign col  = e[0];
   assign term = k_q[0];

   always_comb begin
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            a_el[2*r+c] = a_q[idx(r, c, N) +: N];
            b_el[2*r+c] = b_q[idx(r, c, N) +: N];
         end
      end
   end

   assign op_a = a_el[{row, term}];
   assign op_b = b_el[{term, col}];

   qmult #(.Q(Q), .N(N)) u_qmult (
      .i_multiplicand (op_a),
      .i_multiplier   (op_b),
      .o_result       (prod),
      .ovr            (prod_ovr)
   );

   fx_add_sat #(.N(N)) u_add (
      .a_i   (acc_q),
      .b_i   (prod),
      .sum_o (sum),
      .ovr_o (sum_ovr)
   );

   always_comb begin
      // NOTE: every _d starts from its _q so no branch leaves a signal unassigned (no latch).
      state_d   = state_q;
      k_d       = k_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      res_d     = res_q;
      c_d       = c_q;
      ovr_acc_d = ovr_acc_q;
      ovr_d     = ovr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d       = a_i;
               b_d       = b_i;
               k_d       = 3'd0;
               ovr_acc_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            ovr_acc_d = ovr_acc_q | prod_ovr | (term & sum_ovr);
            if (!term) begin
               acc_d = prod;
            end else begin
               for (int r = 0; r < 2; r++) begin
                  for (int c = 0; c < 2; c++) begin
                     if ({row, col} == {r[0], c[0]}) res_d[idx(r, c, N) +: N] = sum;
                  end
               end
            end
            k_d = k_q + 3'd1;
            // The last element lands in c_o on the same edge that raises done.
            if (k_q == 3'd7) begin
               c_d     = res_d;
               ovr_d   = ovr_acc_d;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking only; operand/result registers are cleared on reset too.
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         c_q       <= '0;
         ovr_acc_q <= 1'b0;
         ovr_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         c_q       <= c_d;
         ovr_acc_q <= ovr_acc_d;
         ovr_q     <= ovr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign c_o  = c_q;
   assign busy = busy_q;
   assign done = done_q;
   assign ovr  = ovr_q;

endmodule
